// File: rtl/d8m_frame_timing_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : d8m_frame_timing_counter_if
//  Purpose  : Bundles the D8M sensor parallel bus (iDATA/iFVAL/iLVAL) and the
//             timing/measurement outputs of d8m_frame_timing_counter.
//  Modports : master - sensor/consumer side (drives i*, observes o*)
//             slave  - counter side (observes i*, drives o*)
//  Revision : 1.0 - initial release
// ============================================================================
interface d8m_frame_timing_counter_if #(
  parameter int DATA_W = 12,
  parameter int X_W    = 16,
  parameter int Y_W    = 16,
  parameter int F_W    = 8
);
  logic [DATA_W-1:0] iDATA;
  logic              iFVAL;
  logic              iLVAL;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [X_W-1:0]    oX;
  logic [Y_W-1:0]    oY;
  logic [X_W-1:0]    oLINE_LEN;
  logic              oLINE_LEN_VLD;
  logic              oLEN_ERR;
  logic [Y_W-1:0]    oFRAME_LINES;
  logic              oFRAME_DONE;
  logic [F_W-1:0]    oFRAME_CNT;
  logic              oTIMEOUT;
  logic              oOVF;

  modport master (
    output iDATA, iFVAL, iLVAL,
    input  oDATA, oDVAL, oX, oY, oLINE_LEN, oLINE_LEN_VLD, oLEN_ERR,
           oFRAME_LINES, oFRAME_DONE, oFRAME_CNT, oTIMEOUT, oOVF
  );

  modport slave (
    input  iDATA, iFVAL, iLVAL,
    output oDATA, oDVAL, oX, oY, oLINE_LEN, oLINE_LEN_VLD, oLEN_ERR,
           oFRAME_LINES, oFRAME_DONE, oFRAME_CNT, oTIMEOUT, oOVF
  );
endinterface
`default_nettype wire

// File: rtl/d8m_frame_timing_counter.sv
`default_nettype none
// ============================================================================
//  Module   : d8m_frame_timing_counter
//  Purpose  : Registers D8M pixel data with aligned X/Y coordinates, measures
//             line length and frame line count, flags length errors and
//             counter saturation, and inserts virtual line advances when LVAL
//             stays absent for LINE_TIMEOUT cycles inside a frame.
//  Ports    : iCLK - pixel clock
//             iRST - synchronous active-high reset
//             bus  - slave view of d8m_frame_timing_counter_if
//                    (iDATA/iFVAL/iLVAL in; data, coordinates, measurements
//                    and status pulses out; all outputs registered)
//  Revision : 1.0 - initial release
// ============================================================================
module d8m_frame_timing_counter #(
  parameter int DATA_W       = 12,
  parameter int X_W          = 16,
  parameter int Y_W          = 16,
  parameter int F_W          = 8,
  parameter int EXP_WIDTH    = 640,
  parameter int LINE_TIMEOUT = 793,
  parameter int TIMEOUT_EN   = 1
) (
  input  wire logic iCLK,
  input  wire logic iRST,
  d8m_frame_timing_counter_if.slave bus
);

  // A timeout of 0 is treated as 1 so the compare value never underflows.
  localparam int            LT_EFF    = (LINE_TIMEOUT < 1) ? 1 : LINE_TIMEOUT;
  localparam int            IDLE_W    = $clog2(LT_EFF + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LT_EFF - 1);
  // An expected width that does not fit in X_W can never match px_cnt.
  localparam bit            EXP_FITS  = ((EXP_WIDTH >> X_W) == 0);
  localparam logic [X_W-1:0] EXP_X    = X_W'(EXP_WIDTH);

  logic              pre_fval_q, pre_fval_d;
  logic              pre_lval_q, pre_lval_d;
  logic [X_W-1:0]    px_cnt_q, px_cnt_d;
  logic [Y_W-1:0]    line_cnt_q, line_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dval_q, dval_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [X_W-1:0]    line_len_q, line_len_d;
  logic              line_vld_q, line_vld_d;
  logic              len_err_q, len_err_d;
  logic [Y_W-1:0]    frame_lines_q, frame_lines_d;
  logic              frame_done_q, frame_done_d;
  logic [F_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic              timeout_q, timeout_d;
  logic              ovf_q, ovf_d;

  logic lval_fall, fval_fall, fval_rise, timeout_fire, sat_evt;

  always_comb begin
    lval_fall = pre_lval_q & ~bus.iLVAL;
    fval_fall = pre_fval_q & ~bus.iFVAL;
    fval_rise = ~pre_fval_q & bus.iFVAL;
    // Only fire inside an idle gap; a real line end this cycle takes over.
    timeout_fire = (TIMEOUT_EN != 0) && bus.iFVAL && !bus.iLVAL &&
                   (idle_cnt_q == IDLE_LAST) && !lval_fall;
    sat_evt = 1'b0;

    pre_fval_d    = bus.iFVAL;
    pre_lval_d    = bus.iLVAL;
    px_cnt_d      = px_cnt_q;
    line_cnt_d    = line_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    line_len_d    = line_len_q;
    line_vld_d    = 1'b0;
    len_err_d     = 1'b0;
    frame_lines_d = frame_lines_q;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    timeout_d     = timeout_fire;
    ovf_d         = ovf_q;

    // Coordinates are the counters before this cycle's update.
    data_d = bus.iDATA;
    dval_d = bus.iFVAL & bus.iLVAL;
    x_d    = px_cnt_q;
    y_d    = line_cnt_q;

    if (lval_fall || fval_rise) begin
      px_cnt_d = '0;
    end else if (bus.iLVAL) begin
      if (&px_cnt_q) sat_evt = 1'b1;
      else           px_cnt_d = px_cnt_q + X_W'(1);
    end

    if (fval_fall || fval_rise) begin
      line_cnt_d = '0;
    end else if (lval_fall || timeout_fire) begin
      if (&line_cnt_q) sat_evt = 1'b1;
      else             line_cnt_d = line_cnt_q + Y_W'(1);
    end

    if (!bus.iFVAL || bus.iLVAL || timeout_fire) begin
      idle_cnt_d = '0;
    end else if (!(&idle_cnt_q)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end

    if (lval_fall) begin
      line_len_d = px_cnt_q;
      line_vld_d = 1'b1;
      len_err_d  = (EXP_WIDTH != 0) && (!EXP_FITS || (px_cnt_q != EXP_X));
    end

    // A line ending on the same cycle as the frame still counts toward it.
    if (fval_fall) begin
      if (lval_fall) begin
        if (&line_cnt_q) begin
          frame_lines_d = line_cnt_q;
          sat_evt       = 1'b1;
        end else begin
          frame_lines_d = line_cnt_q + Y_W'(1);
        end
      end else begin
        frame_lines_d = line_cnt_q;
      end
      frame_done_d = 1'b1;
      frame_cnt_d  = frame_cnt_q + F_W'(1);
    end

    if (sat_evt)        ovf_d = 1'b1;
    else if (fval_rise) ovf_d = 1'b0;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pre_fval_q    <= 1'b0;
      pre_lval_q    <= 1'b0;
      px_cnt_q      <= '0;
      line_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      data_q        <= '0;
      dval_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_len_q    <= '0;
      line_vld_q    <= 1'b0;
      len_err_q     <= 1'b0;
      frame_lines_q <= '0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      timeout_q     <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      pre_fval_q    <= pre_fval_d;
      pre_lval_q    <= pre_lval_d;
      px_cnt_q      <= px_cnt_d;
      line_cnt_q    <= line_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      data_q        <= data_d;
      dval_q        <= dval_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_len_q    <= line_len_d;
      line_vld_q    <= line_vld_d;
      len_err_q     <= len_err_d;
      frame_lines_q <= frame_lines_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_q     <= timeout_d;
      ovf_q         <= ovf_d;
    end
  end

  assign bus.oDATA         = data_q;
  assign bus.oDVAL         = dval_q;
  assign bus.oX            = x_q;
  assign bus.oY            = y_q;
  assign bus.oLINE_LEN     = line_len_q;
  assign bus.oLINE_LEN_VLD = line_vld_q;
  assign bus.oLEN_ERR      = len_err_q;
  assign bus.oFRAME_LINES  = frame_lines_q;
  assign bus.oFRAME_DONE   = frame_done_q;
  assign bus.oFRAME_CNT    = frame_cnt_q;
  assign bus.oTIMEOUT      = timeout_q;
  assign bus.oOVF          = ovf_q;

endmodule
`default_nettype wire

// File: doc/d8m_frame_timing_counter.md
Name: d8m_frame_timing_counter

Overview:
Parametrised successor to the D8M write-side pixel/line counter. It sits between the D8M sensor parallel bus (FVAL/LVAL/DATA) and the frame-buffer write logic. It registers pixel data with aligned X/Y coordinates, measures the length of every line and the line count of every frame, and flags length errors and counter overflow. It also generates virtual line advances on a programmable LVAL-absence timeout.

Parameters:
DATA_W, 12, pixel data width
X_W, 16, pixel counter and line-length width
Y_W, 16, line counter and frame-line-count width
F_W, 8, frame counter width (wraps)
EXP_WIDTH, 640, expected pixels per line; 0 disables length check
LINE_TIMEOUT, 793, idle cycles (FVAL high, LVAL low) before a virtual line advance
TIMEOUT_EN, 1, 1 enables virtual line advance; 0 disables it

Ports:
iCLK  in  1  pixel clock
iRST  in  1  reset; synchronous, active-high
iDATA  in  DATA_W  sensor pixel data
iFVAL  in  1  frame valid
iLVAL  in  1  line valid
oDATA  out  DATA_W  registered iDATA
oDVAL  out  1  registered (iFVAL & iLVAL)
oX  out  X_W  pixel index of oDATA within line, 0-based
oY  out  Y_W  line index of oDATA within frame, 0-based
oLINE_LEN  out  X_W  pixel count of last completed line
oLINE_LEN_VLD  out  1  1-cycle pulse when oLINE_LEN updates
oLEN_ERR  out  1  1-cycle pulse with oLINE_LEN_VLD when length != EXP_WIDTH
oFRAME_LINES  out  Y_W  line count of last completed frame
oFRAME_DONE  out  1  1-cycle pulse when oFRAME_LINES updates
oFRAME_CNT  out  F_W  completed frames, wraps at 2^F_W
oTIMEOUT  out  1  1-cycle pulse on virtual line advance
oOVF  out  1  sticky; any X/Y counter saturated in current frame

Behaviour:
- Reset (iRST=1 at iCLK edge): all outputs and internal registers are 0, including pre_fval, pre_lval, px_cnt, line_cnt and idle_cnt. Reset has priority over every event and aborts any in-progress line or frame without a pulse.
- Edge definitions use the previous-cycle registers: lval_fall = pre_lval & !iLVAL; fval_fall = pre_fval & !iFVAL; fval_rise = !pre_fval & iFVAL.
- px_cnt (X_W):
  - 0 on lval_fall or fval_rise.
  - Otherwise, if iLVAL, increments by 1, saturating at all-ones; saturation sets oOVF.
- Data path, 1-cycle latency: oDATA <= iDATA; oDVAL <= iFVAL & iLVAL; oX <= px_cnt (pre-increment value); oY <= line_cnt. The first pixel of a line therefore has oX=0.
- line_cnt (Y_W), priority order:
  - fval_fall or fval_rise: 0.
  - lval_fall: +1.
  - Timeout advance: +1, and idle_cnt <= 0.
  - Increments saturate at all-ones and set oOVF.
- idle_cnt:
  - Counts cycles with iFVAL=1 and iLVAL=0.
  - Cleared when iLVAL=1, when iFVAL=0, and on timeout.
  - Timeout fires when TIMEOUT_EN=1 and idle_cnt == LINE_TIMEOUT-1; the same cycle pulses oTIMEOUT.
  - Timeout is suppressed in a cycle where lval_fall occurs.
- Line measurement on lval_fall:
  - oLINE_LEN <= px_cnt; oLINE_LEN_VLD=1.
  - oLEN_ERR = (EXP_WIDTH != 0) & (px_cnt != EXP_WIDTH).
  - lval_fall is honoured even while iFVAL=0.
- Frame close on fval_fall:
  - oFRAME_LINES <= line_cnt + (lval_fall ? 1 : 0), saturating. This handles simultaneous LVAL/FVAL fall.
  - oFRAME_DONE=1; oFRAME_CNT <= oFRAME_CNT+1, wrapping.
- oOVF clears on fval_rise; a saturation in the same cycle wins (stays 1).
- All pulse outputs are 0 in every cycle with no event.

Test Plan:
- EXP_WIDTH=4, frame of 3 lines × 4 px, 2-cycle gaps -> oX sequence 0,1,2,3 per line; oY 0,1,2; three oLINE_LEN_VLD pulses with value 4, oLEN_ERR=0; oFRAME_LINES=3, oFRAME_DONE once, oFRAME_CNT=1.
- Line of 5 px with EXP_WIDTH=4 -> oLINE_LEN=5 with oLEN_ERR=1; EXP_WIDTH=0 -> oLEN_ERR stays 0.
- LINE_TIMEOUT=10, FVAL high with LVAL low for 25 cycles -> oTIMEOUT pulses on idle cycles 10 and 20, line_cnt=2. With TIMEOUT_EN=0 -> no pulses, line_cnt=0.
- LVAL and FVAL fall on the same cycle after 2 prior lines -> oLINE_LEN_VLD and oFRAME_DONE in the same cycle, oFRAME_LINES=3.
- X_W=3, line of 10 px -> px_cnt saturates at 7, oOVF=1 until next fval_rise; F_W=2 with 5 frames -> oFRAME_CNT=1.
- iRST asserted mid-line (px_cnt=3, line_cnt=2) -> next cycle all outputs 0, no pulses. After release, a new frame counts from oX=0, oY=0.
